// File: rtl/craps_engine.sv
// ---------------------------------------------------------------------------
// craps_engine -- two-dice craps game controller.
//
// A free-running 16-bit Fibonacci LFSR supplies die candidates. A rising edge
// on the roll button loads both dice, and the dice are then scored as a
// come-out roll or a point roll. Per-game roll count and lifetime win/loss
// tallies are kept in saturating counters.
//
// Parameters
//   FACES  faces per die (4..15)
//   CNT_W  width of roll_cnt / wins / losses
//   SEED   nonzero LFSR reset value
//
// Ports
//   clk_main     in   single clock, rising edge
//   reset        in   synchronous, active-low
//   enter        in   roll button (level)
//   new_game     in   leave WIN/LOSE and return to IDLE
//   die_a/die_b  out  last rolled faces, 1..FACES
//   sum_out      out  die_a + die_b
//   point        out  established point
//   point_valid  out  a point is being held
//   win/lose     out  high while in WIN / LOSE
//   state_out    out  FSM state code
//   roll_cnt     out  rolls in the current game
//   wins/losses  out  games won / lost
//
// Optional feature (macro CRAPS_FORCE_DICE_EN): adds force_valid/force_a/
// force_b. A roll with force_valid high loads force_a/force_b instead of the
// LFSR candidates; the LFSR keeps advancing either way.
// ---------------------------------------------------------------------------
module craps_engine #(
  parameter int          FACES = 6,
  parameter int          CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk_main,
  input  logic             reset,
  input  logic             enter,
  input  logic             new_game,
`ifdef CRAPS_FORCE_DICE_EN
  input  logic             force_valid,
  input  logic [3:0]       force_a,
  input  logic [3:0]       force_b,
`endif
  output logic [3:0]       die_a,
  output logic [3:0]       die_b,
  output logic [4:0]       sum_out,
  output logic [4:0]       point,
  output logic             point_valid,
  output logic             win,
  output logic             lose,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] roll_cnt,
  output logic [CNT_W-1:0] wins,
  output logic [CNT_W-1:0] losses
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EVAL_C = 3'd1,
    S_POINT  = 3'd2,
    S_EVAL_P = 3'd3,
    S_WIN    = 3'd4,
    S_LOSE   = 3'd5
  } state_t;

  localparam logic [3:0] FACES_L = 4'(FACES);
  localparam logic [4:0] SUM_N   = 5'(FACES + 1);     // natural / seven-out
  localparam logic [4:0] SUM_HI  = 5'(2 * FACES - 1); // second come-out winner
  localparam logic [4:0] SUM_MAX = 5'(2 * FACES);     // top craps

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_lfsr;
  logic             r_enter_q;
  logic [3:0]       r_die_a;
  logic [3:0]       r_die_b;
  logic [4:0]       r_point;
  logic             r_point_valid;
  logic [CNT_W-1:0] r_roll_cnt;
  logic [CNT_W-1:0] r_wins;
  logic [CNT_W-1:0] r_losses;

  logic             w_roll;
  logic             w_fb;
  logic [3:0]       w_cand_a;
  logic [3:0]       w_cand_b;
  logic [3:0]       w_load_a;
  logic [3:0]       w_load_b;
  logic [4:0]       w_sum;
  logic             w_do_roll;
  logic             w_set_point;
  logic             w_inc_win;
  logic             w_inc_lose;
  logic             w_clear_game;

  // Taps 16,14,13,11 counted from 1 map onto bits 15,13,12,10.
  assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand_a = (r_lfsr[3:0]  % FACES_L) + 4'd1;
  assign w_cand_b = (r_lfsr[11:8] % FACES_L) + 4'd1;

`ifdef CRAPS_FORCE_DICE_EN
  assign w_load_a = force_valid ? force_a : w_cand_a;
  assign w_load_b = force_valid ? force_b : w_cand_b;
`else
  assign w_load_a = w_cand_a;
  assign w_load_b = w_cand_b;
`endif

  // enter_q resets high, so a button held through reset release is not a roll.
  assign w_roll = enter & ~r_enter_q;
  assign w_sum  = {1'b0, r_die_a} + {1'b0, r_die_b};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_main) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_do_roll    = 1'b0;
    w_set_point  = 1'b0;
    w_inc_win    = 1'b0;
    w_inc_lose   = 1'b0;
    w_clear_game = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_roll) begin
          w_do_roll    = 1'b1;
          w_next_state = S_EVAL_C;
        end
      end
      S_EVAL_C: begin
        if (w_sum == SUM_N || w_sum == SUM_HI) begin
          w_inc_win    = 1'b1;
          w_next_state = S_WIN;
        end else if (w_sum == 5'd2 || w_sum == 5'd3 || w_sum == SUM_MAX) begin
          w_inc_lose   = 1'b1;
          w_next_state = S_LOSE;
        end else begin
          w_set_point  = 1'b1;
          w_next_state = S_POINT;
        end
      end
      S_POINT: begin
        if (w_roll) begin
          w_do_roll    = 1'b1;
          w_next_state = S_EVAL_P;
        end
      end
      S_EVAL_P: begin
        // Making the point is tested before seven-out.
        if (w_sum == r_point) begin
          w_inc_win    = 1'b1;
          w_next_state = S_WIN;
        end else if (w_sum == SUM_N) begin
          w_inc_lose   = 1'b1;
          w_next_state = S_LOSE;
        end else begin
          w_next_state = S_POINT;
        end
      end
      S_WIN, S_LOSE: begin
        // Rolls are ignored here; new_game alone leaves the terminal state.
        if (new_game) begin
          w_clear_game = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (!reset) begin
      r_lfsr        <= SEED;
      r_enter_q     <= 1'b1;
      r_die_a       <= 4'd1;
      r_die_b       <= 4'd1;
      r_point       <= '0;
      r_point_valid <= 1'b0;
      r_roll_cnt    <= '0;
      r_wins        <= '0;
      r_losses      <= '0;
    end else begin
      r_lfsr    <= {r_lfsr[14:0], w_fb};
      r_enter_q <= enter;
      if (w_do_roll) begin
        r_die_a <= w_load_a;
        r_die_b <= w_load_b;
        if (r_roll_cnt != '1) r_roll_cnt <= r_roll_cnt + CNT_W'(1);
      end
      if (w_set_point) begin
        r_point       <= w_sum;
        r_point_valid <= 1'b1;
      end
      if (w_inc_win && r_wins != '1)    r_wins   <= r_wins + CNT_W'(1);
      if (w_inc_lose && r_losses != '1) r_losses <= r_losses + CNT_W'(1);
      if (w_clear_game) begin
        r_point       <= '0;
        r_point_valid <= 1'b0;
        r_roll_cnt    <= '0;
      end
    end
  end

  assign die_a       = r_die_a;
  assign die_b       = r_die_b;
  assign sum_out     = w_sum;
  assign point       = r_point;
  assign point_valid = r_point_valid;
  assign win         = (r_state == S_WIN);
  assign lose        = (r_state == S_LOSE);
  assign state_out   = r_state;
  assign roll_cnt    = r_roll_cnt;
  assign wins        = r_wins;
  assign losses      = r_losses;

endmodule

// File: tb/tb_craps_engine.sv
// ---------------------------------------------------------------------------
// tb_craps_engine -- scoreboard bench for craps_engine (FACES=6).
//
// The bench keeps its own model of the dice LFSR and times each button press
// so the rolled dice equal a hand-chosen pair. Each roll pushes the expected
// resolved game state into a queue; a monitor pops and compares whenever the
// DUT leaves an evaluation state. A second instance with CNT_W=2 shares all
// inputs to exercise win-counter saturation.
// ---------------------------------------------------------------------------
module tb_craps_engine;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] pt;
    logic       pv;
    logic [7:0] rc;
    logic [7:0] w;
    logic [7:0] l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enter;
  logic new_game;
  logic force_valid = 1'b0;
  logic [3:0] force_a = 4'd0;
  logic [3:0] force_b = 4'd0;

  logic [3:0] die_a, die_b;
  logic [4:0] sum_out, point;
  logic       point_valid, win, lose;
  logic [2:0] state_out;
  logic [7:0] roll_cnt, wins, losses;

  logic [3:0] s_die_a, s_die_b;
  logic [4:0] s_sum, s_point;
  logic       s_pv, s_win, s_lose;
  logic [2:0] s_state;
  logic [1:0] s_roll_cnt, s_wins, s_losses;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  craps_engine #(.FACES(6), .CNT_W(8), .SEED(16'hACE1)) u_dut (
    .clk_main(clk), .reset(rst), .enter(enter), .new_game(new_game),
`ifdef CRAPS_FORCE_DICE_EN
    .force_valid(force_valid), .force_a(force_a), .force_b(force_b),
`endif
    .die_a(die_a), .die_b(die_b), .sum_out(sum_out), .point(point),
    .point_valid(point_valid), .win(win), .lose(lose), .state_out(state_out),
    .roll_cnt(roll_cnt), .wins(wins), .losses(losses)
  );

  craps_engine #(.FACES(6), .CNT_W(2), .SEED(16'hACE1)) u_sat (
    .clk_main(clk), .reset(rst), .enter(enter), .new_game(new_game),
`ifdef CRAPS_FORCE_DICE_EN
    .force_valid(force_valid), .force_a(force_a), .force_b(force_b),
`endif
    .die_a(s_die_a), .die_b(s_die_b), .sum_out(s_sum), .point(s_point),
    .point_valid(s_pv), .win(s_win), .lose(s_lose), .state_out(s_state),
    .roll_cnt(s_roll_cnt), .wins(s_wins), .losses(s_losses)
  );

  // Reference LFSR: taps 16,14,13,11, reloaded with the seed during reset.
  always @(posedge clk) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int cand(input logic [3:0] v);
    return int'(v) % 6 + 1;
  endfunction

  function automatic exp_t mk(input int st, input int pt, input int pv,
                              input int rc, input int w, input int l);
    exp_t e;
    e.st = 3'(st);
    e.pt = 5'(pt);
    e.pv = 1'(pv);
    e.rc = 8'(rc);
    e.w  = 8'(w);
    e.l  = 8'(l);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one cycle after an evaluation state, the game has resolved.
  initial begin
    bit   eval_seen;
    exp_t e;
    eval_seen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        eval_seen = 1'b0;
      end else begin
        if (eval_seen) begin
          check("expectation_present", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_state",       state_out,   e.st);
            check("res_win",         win,         e.st == 3'd4);
            check("res_lose",        lose,        e.st == 3'd5);
            check("res_point",       point,       e.pt);
            check("res_point_valid", point_valid, e.pv);
            check("res_roll_cnt",    roll_cnt,    e.rc);
            check("res_wins",        wins,        e.w);
            check("res_losses",      losses,      e.l);
          end
        end
        eval_seen = (state_out == 3'd1 || state_out == 3'd3);
      end
    end
  end

  // Wait until the LFSR offers dice a/b, press enter, and hold it for 'hold'
  // cycles. 'ev' is the evaluation state expected right after the roll.
  // With abort set no resolution is expected (the caller resets instead).
  task automatic do_roll(input int a, input int b, input int hold, input bit abort,
                         input int ev, input exp_t e);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (cand(m_lfsr[3:0]) == a && cand(m_lfsr[11:8]) == b) found = 1'b1;
    end
    check("roll_found", 32'(found), 1);
    if (!found) return;
    enter = 1'b1;
    if (!abort) exp_q.push_back(e);
    @(negedge clk);
    check("roll_die_a", die_a, a);
    check("roll_die_b", die_b, b);
    check("roll_sum",   sum_out, a + b);
    check("roll_eval",  state_out, ev);
    if (abort) begin
      enter = 1'b0;
      return;
    end
    repeat (hold - 1) @(negedge clk);
    enter = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("resolved", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("ng_state",    state_out, 0);
    check("ng_roll_cnt", roll_cnt, 0);
    check("ng_pv",       point_valid, 0);
    check("ng_point",    point, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  state_out, 0);
    check({tag, "_die_a"},  die_a, 1);
    check({tag, "_die_b"},  die_b, 1);
    check({tag, "_sum"},    sum_out, 2);
    check({tag, "_point"},  point, 0);
    check({tag, "_pv"},     point_valid, 0);
    check({tag, "_win"},    win, 0);
    check({tag, "_lose"},   lose, 0);
    check({tag, "_rc"},     roll_cnt, 0);
    check({tag, "_wins"},   wins, 0);
    check({tag, "_losses"}, losses, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enter = 1'b0; new_game = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // Come-out natural, then new_game with a simultaneous press.
    do_roll(3, 4, 1, 1'b0, 1, mk(4, 0, 0, 1, 1, 0));
    @(negedge clk);
    enter = 1'b1; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("ng_roll_state", state_out, 0);
    check("ng_roll_rc",    roll_cnt, 0);
    check("ng_dice_hold",  {die_a, die_b}, {4'd3, 4'd4});
    check("ng_wins_hold",  wins, 1);
    @(negedge clk);
    check("ng_held_state", state_out, 0);
    check("ng_held_rc",    roll_cnt, 0);
    enter = 1'b0;
    @(negedge clk);

    // Come-out craps: 2 and 12.
    do_roll(1, 1, 1, 1'b0, 1, mk(5, 0, 0, 1, 1, 1));
    start_new_game();
    do_roll(6, 6, 1, 1'b0, 1, mk(5, 0, 0, 1, 1, 2));
    start_new_game();

    // Point 4, miss, then make the point.
    do_roll(2, 2, 1, 1'b0, 1, mk(2, 4, 1, 1, 1, 2));
    do_roll(5, 1, 1, 1'b0, 3, mk(2, 4, 1, 2, 1, 2));
    do_roll(3, 1, 1, 1'b0, 3, mk(4, 4, 1, 3, 2, 2));
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    check("win_ignore_state", state_out, 4);
    check("win_ignore_rc",    roll_cnt, 3);
    @(negedge clk);
    start_new_game();

    // Point 8, seven-out.
    do_roll(4, 4, 1, 1'b0, 1, mk(2, 8, 1, 1, 2, 2));
    do_roll(3, 4, 1, 1'b0, 3, mk(5, 8, 1, 2, 2, 3));
    start_new_game();

    // Eleven with enter held 10 cycles: exactly one roll.
    do_roll(6, 5, 10, 1'b0, 1, mk(4, 0, 0, 1, 3, 3));
    check("held_rc",    roll_cnt, 1);
    check("held_state", state_out, 4);
    start_new_game();

    // Enter held through reset release.
    @(negedge clk);
    enter = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_held_state", state_out, 0);
    check("rst_held_rc",    roll_cnt, 0);
    enter = 1'b0;
    @(negedge clk);

    // Reset during EVAL_P of a seven-out roll.
    do_roll(2, 2, 1, 1'b0, 1, mk(2, 4, 1, 1, 0, 0));
    do_roll(3, 4, 1, 1'b1, 3, mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    rst = 1'b1;
    @(negedge clk);

    // Five wins: 8-bit counter reaches 5, 2-bit counter saturates at 3.
    for (int i = 1; i <= 5; i++) begin
      do_roll(3, 4, 1, 1'b0, 1, mk(4, 0, 0, 1, i, 0));
      start_new_game();
    end
    check("sat_wins",        s_wins, 3);
    check("sat_losses",      s_losses, 0);
    check("full_wins",       wins, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
